// File: rtl/reply_arbiter_pkg.sv
// Shared types and constants for the reply-path arbiter: frame prefix, source
// count, FSM encoding and the latched grant context.
package reply_arbiter_pkg;

  localparam int unsigned N_SRC  = 8;
  localparam int unsigned ID_W   = $clog2(N_SRC);
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CRC_W  = 8;

  localparam logic [BYTE_W-1:0] PREFIX = 8'hAA;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFIX,
    S_DEST,
    S_LEN,
    S_FETCH,
    S_DATA,
    S_CRC
  } state_t;

  // Grant locked for the duration of one frame
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [N_SRC-1:0]  gnt;
    logic [BYTE_W-1:0] len;
  } grant_t;

endpackage

// File: rtl/reply_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter
  import reply_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_SRC
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] id
);

  localparam int unsigned IW = $clog2(N_REQ);

  logic          found;
  logic [IW-1:0] k;

  always_comb begin
    gnt   = '0;
    id    = '0;
    found = 1'b0;
    k     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = IW'((32'(ptr) + i) % N_REQ);
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        id     = k;
      end
    end
  end

endmodule

// File: rtl/reply_arbiter.sv
// Round-robin framer sharing one UART TX byte stream among N_SRC reply sources,
// one whole frame (PREFIX, id, len, data, crc) at a time, with a stall watchdog.
module reply_arbiter
  import reply_arbiter_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = 50_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC-1:0]        src_req,
  input  logic [BYTE_W*N_SRC-1:0] src_len,
  input  logic [BYTE_W*N_SRC-1:0] src_q,
  output logic [N_SRC-1:0]        src_rdreq,
  output logic [N_SRC-1:0]        src_done,
  output logic [N_SRC-1:0]        src_flush,
  output logic [BYTE_W-1:0]       tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy
);

  localparam int unsigned STALL_W = $clog2(STALL_LIMIT);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT - 1);

  logic [BYTE_W-1:0] len_a [N_SRC];
  logic [BYTE_W-1:0] q_a   [N_SRC];

  for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
    assign len_a[g] = src_len[BYTE_W*g +: BYTE_W];
    assign q_a[g]   = src_q[BYTE_W*g +: BYTE_W];
  end

  state_t             state_q, state_d;
  grant_t             cur_q, cur_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [BYTE_W-1:0]  cnt_q, cnt_d;
  logic [CRC_W-1:0]   crc_q, crc_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [BYTE_W-1:0]  byte_q, byte_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic [N_SRC-1:0]   rdreq_q, rdreq_d;
  logic [N_SRC-1:0]   done_q, done_d;
  logic [N_SRC-1:0]   flush_q, flush_d;

  logic [N_SRC-1:0]  arb_req;
  logic [N_SRC-1:0]  arb_gnt;
  logic [ID_W-1:0]   arb_id;
  logic              accept;
  logic [BYTE_W-1:0] cur_byte;
  logic [CRC_W-1:0]  crc_sum;
  logic [CRC_W-1:0]  crc_hdr;
  logic [BYTE_W-1:0] cnt_inc;

  // A source that just finished or aborted still holds src_req this cycle; skip it
  assign arb_req  = src_req & ~(done_q | flush_q);
  assign accept   = valid_q & tx_ready;
  assign cur_byte = q_a[cur_q.id];
  assign crc_sum  = crc_q + cur_byte;
  assign crc_hdr  = CRC_W'(cur_q.id) + cur_q.len;
  assign cnt_inc  = cnt_q + BYTE_W'(1);

  rr_arbiter #(.N_REQ(N_SRC)) u_rr (
    .req (arb_req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .id  (arb_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      crc_q   <= '0;
      stall_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      rdreq_q <= '0;
      done_q  <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      stall_q <= stall_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      rdreq_q <= rdreq_d;
      done_q  <= done_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    stall_d = stall_q;
    byte_d  = byte_q;
    rdreq_d = '0;
    done_d  = '0;
    flush_d = '0;

    case (state_q)
      S_IDLE: begin
        stall_d = '0;
        if (|arb_req) begin
          cur_d.id  = arb_id;
          cur_d.gnt = arb_gnt;
          cur_d.len = len_a[arb_id];
          ptr_d     = (arb_id == ID_W'(N_SRC - 1)) ? '0 : arb_id + ID_W'(1);
          byte_d    = PREFIX;
          state_d   = S_PREFIX;
        end
      end
      S_PREFIX: if (accept) begin
        byte_d  = BYTE_W'(cur_q.id);
        state_d = S_DEST;
      end
      S_DEST: if (accept) begin
        byte_d  = cur_q.len;
        state_d = S_LEN;
      end
      S_LEN: if (accept) begin
        crc_d = crc_hdr;
        if (cur_q.len != '0) begin
          byte_d  = '0;
          rdreq_d = cur_q.gnt;
          state_d = S_FETCH;
        end else begin
          byte_d  = crc_hdr;
          state_d = S_CRC;
        end
      end
      S_FETCH: state_d = S_DATA;
      // Data byte comes straight from the FIFO output, which holds until the next pop
      S_DATA: if (accept) begin
        crc_d = crc_sum;
        cnt_d = cnt_inc;
        if (cnt_inc == cur_q.len) begin
          byte_d  = crc_sum;
          state_d = S_CRC;
        end else begin
          rdreq_d = cur_q.gnt;
          state_d = S_FETCH;
        end
      end
      S_CRC: if (accept) begin
        done_d  = cur_q.gnt;
        cnt_d   = '0;
        crc_d   = '0;
        byte_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Watchdog: abandon the frame if the transmitter refuses bytes for too long
    if (valid_q && !tx_ready) begin
      if (stall_q == STALL_MAX) begin
        flush_d = cur_q.gnt;
        cnt_d   = '0;
        crc_d   = '0;
        byte_d  = '0;
        stall_d = '0;
        state_d = S_IDLE;
      end else begin
        stall_d = stall_q + STALL_W'(1);
      end
    end else if (accept) begin
      stall_d = '0;
    end

    valid_d = state_d inside {S_PREFIX, S_DEST, S_LEN, S_DATA, S_CRC};
    busy_d  = (state_d != S_IDLE);
  end

  assign src_rdreq = rdreq_q;
  assign src_done  = done_q;
  assign src_flush = flush_q;
  assign tx_valid  = valid_q;
  assign busy      = busy_q;
  assign tx_data   = (state_q == S_DATA) ? cur_byte : byte_q;

endmodule

// File: tb/tb_reply_arbiter.sv
// Directed bench for reply_arbiter: per-source FIFO model, scripted tx_ready.
module tb_reply_arbiter;
  import reply_arbiter_pkg::*;

  localparam int unsigned LIMIT = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_SRC-1:0]        src_req;
  logic [BYTE_W*N_SRC-1:0] src_len;
  logic [BYTE_W*N_SRC-1:0] src_q;
  logic [N_SRC-1:0]        src_rdreq;
  logic [N_SRC-1:0]        src_done;
  logic [N_SRC-1:0]        src_flush;
  logic [BYTE_W-1:0]       tx_data;
  logic                    tx_valid;
  logic                    tx_ready;
  logic                    busy;

  always #5 clk = ~clk;

  reply_arbiter #(.STALL_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_req   (src_req),
    .src_len   (src_len),
    .src_q     (src_q),
    .src_rdreq (src_rdreq),
    .src_done  (src_done),
    .src_flush (src_flush),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy)
  );

  // Normal-mode FIFO per source: q updates on the edge that samples rdreq
  logic [7:0] fifo_mem [N_SRC][8];
  logic [2:0] rd_idx   [N_SRC];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SRC; i++) rd_idx[i] <= '0;
      src_q <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (src_rdreq[i]) begin
          src_q[8*i +: 8] <= fifo_mem[i][rd_idx[i]];
          rd_idx[i]       <= rd_idx[i] + 3'd1;
        end
      end
    end
  end

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] obs[$];
  logic [7:0] exp_b[$];
  int         done_ids[$];
  int         flush_ids[$];
  int         frames_left[N_SRC];
  int         rdreq_cnt;
  int         stall_cycles;
  bit         flush_seen;
  logic       flush_valid;
  logic       flush_busy;

  task automatic load(input int s, input logic [7:0] len,
                      input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                      input logic [7:0] d3, input logic [7:0] d4);
    fifo_mem[s][0] = d0;
    fifo_mem[s][1] = d1;
    fifo_mem[s][2] = d2;
    fifo_mem[s][3] = d3;
    fifo_mem[s][4] = d4;
    src_len[8*s +: 8] = len;
  endtask

  task automatic clear_log();
    obs.delete();
    done_ids.delete();
    flush_ids.delete();
    rdreq_cnt    = 0;
    stall_cycles = 0;
    flush_seen   = 0;
    flush_valid  = 1'bx;
    flush_busy   = 1'bx;
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    src_req  = '0;
    tx_ready = 1'b0;
    for (int i = 0; i < N_SRC; i++) frames_left[i] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // mode 0: ready=1; 1: fixed toggling pattern; 2: ready drops after 3 bytes until a flush
  task automatic run(input int mode, input int max_cycles, input int stop_bytes);
    bit         hold;
    bit         fin;
    logic [7:0] held;
    hold = 0;
    fin  = 0;
    held = '0;
    for (int c = 0; c < max_cycles && !fin; c++) begin
      @(posedge clk);
      #1;
      if (mode == 1)      tx_ready = ((c % 3) == 1) || ((c % 4) == 0);
      else if (mode == 2) tx_ready = (obs.size() < 3) || flush_seen;
      else                tx_ready = 1'b1;
      #1;
      if (hold && src_flush == '0) begin
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== held) begin
          n_fail++;
          $display("FAIL hold_stable: valid=%b data=%h, required valid=1 data=%h", tx_valid, tx_data, held);
        end
      end
      hold = tx_valid && !tx_ready;
      held = tx_data;
      if (tx_valid && !tx_ready) stall_cycles++;
      if (|src_rdreq) rdreq_cnt++;
      if (tx_valid && tx_ready) obs.push_back(tx_data);
      for (int i = 0; i < N_SRC; i++) begin
        if (src_done[i]) begin
          done_ids.push_back(i);
          frames_left[i]--;
        end
        if (src_flush[i]) begin
          flush_ids.push_back(i);
          frames_left[i] = 0;
          flush_seen     = 1;
          flush_valid    = tx_valid;
          flush_busy     = busy;
        end
        src_req[i] = (frames_left[i] > 0);
      end
      if (stop_bytes > 0 && obs.size() >= stop_bytes) fin = 1;
      if (stop_bytes == 0 && src_req == '0 && !busy) fin = 1;
    end
    n_checks++;
    if (!fin) begin
      n_fail++;
      $display("FAIL run_timeout: got %0d bytes after %0d cycles, required completion", obs.size(), max_cycles);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks += 6;
    if (tx_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_tx_valid: got %b, required 0", tx_valid); end
    if (tx_data !== 8'h00)  begin n_fail++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (src_rdreq !== '0)   begin n_fail++; $display("FAIL reset_rdreq: got %b, required 0", src_rdreq); end
    if (src_done !== '0)    begin n_fail++; $display("FAIL reset_done: got %b, required 0", src_done); end
    if (src_flush !== '0)   begin n_fail++; $display("FAIL reset_flush: got %b, required 0", src_flush); end
  endtask

  task automatic test_single_frame();
    clear_log();
    load(2, 8'd3, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00);
    frames_left[2] = 1;
    src_req        = 8'b0000_0100;
    run(0, 200, 0);
    exp_b = '{8'hAA, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6B};
    n_checks++;
    if (obs.size() != exp_b.size()) begin n_fail++; $display("FAIL single_len: got %0d bytes, required %0d", obs.size(), exp_b.size()); end
    for (int k = 0; k < obs.size() && k < exp_b.size(); k++) begin
      n_checks++;
      if (obs[k] !== exp_b[k]) begin n_fail++; $display("FAIL single_byte%0d: got %h, required %h", k, obs[k], exp_b[k]); end
    end
    n_checks += 2;
    if (done_ids.size() != 1 || done_ids[0] != 2) begin n_fail++; $display("FAIL single_done: got %0d pulses, required 1 on src 2", done_ids.size()); end
    if (rdreq_cnt != 3) begin n_fail++; $display("FAIL single_rdreq: got %0d, required 3", rdreq_cnt); end
  endtask

  task automatic test_zero_length();
    clear_log();
    load(7, 8'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    frames_left[7] = 1;
    src_req        = 8'b1000_0000;
    run(0, 200, 0);
    exp_b = '{8'hAA, 8'h07, 8'h00, 8'h07};
    n_checks++;
    if (obs.size() != exp_b.size()) begin n_fail++; $display("FAIL zero_len: got %0d bytes, required %0d", obs.size(), exp_b.size()); end
    for (int k = 0; k < obs.size() && k < exp_b.size(); k++) begin
      n_checks++;
      if (obs[k] !== exp_b[k]) begin n_fail++; $display("FAIL zero_byte%0d: got %h, required %h", k, obs[k], exp_b[k]); end
    end
    n_checks += 2;
    if (rdreq_cnt != 0) begin n_fail++; $display("FAIL zero_rdreq: got %0d, required 0", rdreq_cnt); end
    if (done_ids.size() != 1 || done_ids[0] != 7) begin n_fail++; $display("FAIL zero_done: got %0d pulses, required 1 on src 7", done_ids.size()); end
  endtask

  // Follows the src 7 frame without reset, so the pointer has wrapped to 0
  task automatic test_round_robin();
    int exp_ids[4];
    clear_log();
    load(0, 8'd1, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00);
    load(5, 8'd1, 8'h50, 8'h51, 8'h00, 8'h00, 8'h00);
    frames_left[0] = 2;
    frames_left[5] = 2;
    src_req        = 8'b0010_0001;
    run(0, 400, 0);
    exp_ids = '{0, 5, 0, 5};
    n_checks++;
    if (done_ids.size() != 4) begin n_fail++; $display("FAIL rr_count: got %0d frames, required 4", done_ids.size()); end
    for (int k = 0; k < done_ids.size() && k < 4; k++) begin
      n_checks++;
      if (done_ids[k] != exp_ids[k]) begin n_fail++; $display("FAIL rr_order%0d: got src %0d, required src %0d", k, done_ids[k], exp_ids[k]); end
    end
    exp_b = '{8'hAA, 8'h00, 8'h01, 8'h01, 8'h02, 8'hAA, 8'h05, 8'h01, 8'h50, 8'h56,
              8'hAA, 8'h00, 8'h01, 8'h02, 8'h03, 8'hAA, 8'h05, 8'h01, 8'h51, 8'h57};
    n_checks++;
    if (obs.size() != exp_b.size()) begin n_fail++; $display("FAIL rr_len: got %0d bytes, required %0d", obs.size(), exp_b.size()); end
    for (int k = 0; k < obs.size() && k < exp_b.size(); k++) begin
      n_checks++;
      if (obs[k] !== exp_b[k]) begin n_fail++; $display("FAIL rr_byte%0d: got %h, required %h", k, obs[k], exp_b[k]); end
    end
  endtask

  task automatic test_backpressure();
    clear_log();
    load(1, 8'd4, 8'h10, 8'h20, 8'h30, 8'h40, 8'h00);
    frames_left[1] = 1;
    src_req        = 8'b0000_0010;
    run(1, 400, 0);
    exp_b = '{8'hAA, 8'h01, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA5};
    n_checks++;
    if (obs.size() != exp_b.size()) begin n_fail++; $display("FAIL bp_len: got %0d bytes, required %0d", obs.size(), exp_b.size()); end
    for (int k = 0; k < obs.size() && k < exp_b.size(); k++) begin
      n_checks++;
      if (obs[k] !== exp_b[k]) begin n_fail++; $display("FAIL bp_byte%0d: got %h, required %h", k, obs[k], exp_b[k]); end
    end
    n_checks += 2;
    if (stall_cycles == 0) begin n_fail++; $display("FAIL bp_stalls: got %0d stalled cycles, required >0", stall_cycles); end
    if (done_ids.size() != 1 || done_ids[0] != 1) begin n_fail++; $display("FAIL bp_done: got %0d pulses, required 1 on src 1", done_ids.size()); end
  endtask

  task automatic test_stall_abort();
    clear_log();
    load(3, 8'd2, 8'h31, 8'h32, 8'h00, 8'h00, 8'h00);
    load(6, 8'd1, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00);
    frames_left[3] = 1;
    frames_left[6] = 1;
    src_req        = 8'b0100_1000;
    run(2, 400, 0);
    n_checks += 5;
    if (flush_ids.size() != 1 || flush_ids[0] != 3) begin n_fail++; $display("FAIL stall_flush: got %0d flushes, required 1 on src 3", flush_ids.size()); end
    if (stall_cycles != LIMIT) begin n_fail++; $display("FAIL stall_cycles: got %0d, required %0d", stall_cycles, LIMIT); end
    if (flush_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid: got %b at flush, required 0", flush_valid); end
    if (flush_busy !== 1'b0) begin n_fail++; $display("FAIL stall_busy: got %b at flush, required 0", flush_busy); end
    if (done_ids.size() != 1 || done_ids[0] != 6) begin n_fail++; $display("FAIL stall_next: got %0d frames done, required 1 on src 6", done_ids.size()); end
    exp_b = '{8'hAA, 8'h03, 8'h02, 8'hAA, 8'h06, 8'h01, 8'h66, 8'h6D};
    n_checks++;
    if (obs.size() != exp_b.size()) begin n_fail++; $display("FAIL stall_len: got %0d bytes, required %0d", obs.size(), exp_b.size()); end
    for (int k = 0; k < obs.size() && k < exp_b.size(); k++) begin
      n_checks++;
      if (obs[k] !== exp_b[k]) begin n_fail++; $display("FAIL stall_byte%0d: got %h, required %h", k, obs[k], exp_b[k]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_log();
    load(4, 8'd5, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45);
    frames_left[4] = 1;
    src_req        = 8'b0001_0000;
    run(0, 200, 4);
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h42) begin n_fail++; $display("FAIL midrst_pre: valid=%b data=%h, required 1/42", tx_valid, tx_data); end
    rst = 1'b1;
    @(posedge clk);
    #2;
    n_checks += 4;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_tx: valid=%b data=%h, required 0/00", tx_valid, tx_data); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    if (src_done !== '0 || src_flush !== '0) begin n_fail++; $display("FAIL midrst_pulse: done=%b flush=%b, required 0/0", src_done, src_flush); end
    if (src_rdreq !== '0) begin n_fail++; $display("FAIL midrst_rdreq: got %b, required 0", src_rdreq); end
    rst = 1'b0;
    clear_log();
    run(0, 200, 0);
    exp_b = '{8'hAA, 8'h04, 8'h05, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h58};
    n_checks++;
    if (obs.size() != exp_b.size()) begin n_fail++; $display("FAIL midrst_len: got %0d bytes, required %0d", obs.size(), exp_b.size()); end
    for (int k = 0; k < obs.size() && k < exp_b.size(); k++) begin
      n_checks++;
      if (obs[k] !== exp_b[k]) begin n_fail++; $display("FAIL midrst_byte%0d: got %h, required %h", k, obs[k], exp_b[k]); end
    end
    n_checks++;
    if (done_ids.size() != 1 || done_ids[0] != 4) begin n_fail++; $display("FAIL midrst_done: got %0d pulses, required 1 on src 4", done_ids.size()); end
  endtask

  initial begin
    rst      = 1'b1;
    src_req  = '0;
    src_len  = '0;
    tx_ready = 1'b0;
    for (int s = 0; s < N_SRC; s++)
      for (int k = 0; k < 8; k++) fifo_mem[s][k] = '0;
    test_reset();
    test_single_frame();
    test_zero_length();
    test_round_robin();
    apply_reset();
    test_backpressure();
    apply_reset();
    test_stall_abort();
    apply_reset();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
